spi_master_fifo: RTL
====================

Name: spi_master_fifo

Overview:
Parametrised SPI master. Generalises the fixed 8-bit master/slave interface to a configurable word width, TX/RX FIFO buffering, all four CPOL/CPHA modes, a programmable S_CLK divider and multiple chip selects. Sits between the host register bus (WRITE/READ/data/status) and the SPI pins, and runs back-to-back frames without host intervention while the TX FIFO has data.

Parameters:
DATA_W, 8, bits per SPI word (4..32).
FIFO_DEPTH, 4, entries in each of the TX and RX FIFOs (power of 2, >=2).
NUM_CS, 2, number of active-low chip-select outputs.
DIV_W, 8, width of the clock-divider field.

Ports:
CLK  in  1  system clock; all logic on the rising edge.
CLR  in  1  asynchronous active-low reset.
ENABLE  in  1  1 = engine may start new frames. Clearing it never aborts a frame in progress.
CPOL  in  1  S_CLK idle level; sampled only in IDLE.
CPHA  in  1  0 = sample on leading edge, 1 = sample on trailing edge; sampled only in IDLE.
CONT  in  1  1 = keep CS asserted between back-to-back words.
CS_SEL  in  clog2(NUM_CS)  target slave; latched at frame start.
DIV  in  DIV_W  S_CLK half-period = DIV+1 CLK cycles; latched at frame start.
WRITE  in  1  push INCOMING_DATA into the TX FIFO.
INCOMING_DATA  in  DATA_W  TX word.
READ  in  1  pop the RX FIFO.
OUTCOMING_DATA  out  DATA_W  RX FIFO head (first-word fall-through).
OVF_CLR  in  1  clear RX_OVF.
TX_FULL, TX_EMPTY, RX_FULL, RX_EMPTY  out  1 each  FIFO flags.
BUSY  out  1  engine not in IDLE.
RX_OVF  out  1  sticky; set when a received word is dropped.
S_CLK  out  1  SPI clock.
MOSI  out  1  serial out, MSB first.
MISO  in  1  serial in, MSB first.
CS_N  out  NUM_CS  chip selects, active low.

Behaviour:
- Reset (CLR=0, async): both FIFOs empty, TX_EMPTY=RX_EMPTY=1, TX_FULL=RX_FULL=0, BUSY=0, RX_OVF=0, CS_N all 1, S_CLK=0, MOSI=0, OUTCOMING_DATA=0. Reset during a frame aborts it; the partial word is lost.
- TX FIFO: WRITE when full is ignored. WRITE on a full FIFO in the same cycle the engine pops is accepted; the count is unchanged.
- RX FIFO: READ when empty is ignored; OUTCOMING_DATA holds its value. READ and an engine push in the same cycle on a full FIFO: both take effect.
- OUTCOMING_DATA is updated one cycle after each pop or after the first push into an empty FIFO.
- State machine:
  - IDLE: S_CLK follows the latched CPOL. Go to SETUP when ENABLE=1 and !TX_EMPTY: pop TX, latch DIV/CS_SEL/CPHA, assert CS_N[CS_SEL], drive MOSI with the word's MSB.
  - SETUP: wait one half-period, then go to SHIFT.
  - SHIFT: 2*DATA_W S_CLK edges, one every DIV+1 cycles.
    - CPHA=0: sample MISO on odd (leading) edges; shift MOSI on even (trailing) edges, except after the last edge.
    - CPHA=1: shift MOSI on leading edges (the first leading edge drives the MSB); sample on trailing edges.
    - After the last edge go to DONE.
  - DONE: push the RX word, or if RX is full drop it and set RX_OVF. Then:
    - if CONT=1, ENABLE=1 and !TX_EMPTY: pop the next word and go to SETUP with CS held low, keeping the latched DIV and CS_SEL;
    - otherwise go to HOLD.
  - HOLD: one half-period with CS low, then deassert CS_N and stay one more half-period with CS high, then go to IDLE.
- BUSY=1 in every state except IDLE.
- Frame length for a single word: (2*DATA_W+3)*(DIV+1) CLK cycles from the pop to the return to IDLE.
- S_CLK returns to CPOL level at the end of SHIFT. There are no glitches on S_CLK or CS_N.
- RX_OVF: set has priority over OVF_CLR in the same cycle.
- The divider counter is DIV_W bits. DIV=0 gives S_CLK=CLK/2.

Test Plan:
1. Mode 0, DIV=0, CS_SEL=1: write 0xA5; loopback MISO=MOSI -> CS_N=2'b01 for the whole frame, 8 rising edges, RX head=0xA5, BUSY high for 19 cycles, TX_EMPTY=1 at the end.
2. Modes 1, 2 and 3, DIV=3: send 0x3C against a slave model returning 0xC3 -> RX=0xC3 in each mode; S_CLK idle level equals CPOL; half-period is 4 cycles.
3. FIFO_DEPTH=4, ENABLE=0: write 5 words -> TX_FULL after 4, 5th ignored. Set ENABLE=1 with CONT=1 -> 4 frames with CS continuously low, RX gets 4 words, RX_FULL=1.
4. RX full with no READ, send one more word -> word dropped, RX_OVF=1. Assert OVF_CLR -> RX_OVF=0. READ x4 returns the words in order, then RX_EMPTY=1.
5. Assert CLR mid-SHIFT (bit 3) -> CS_N all 1, S_CLK=0, BUSY=0 immediately; FIFOs empty; the next frame after CLR release completes normally.
6. Clear ENABLE mid-frame with 2 words queued -> the current frame completes, the second word stays in TX (TX_EMPTY=0), BUSY=0.

Source files
------------

// File: rtl/spi_master_fifo.sv
// SPI master with TX/RX FIFO buffering, all four CPOL/CPHA modes, a programmable S_CLK
// divider and NUM_CS active-low chip selects; frames run back-to-back while TX has data.
module spi_master_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_CS     = 2,
  parameter int DIV_W      = 8,
  localparam int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              ENABLE,
  input  logic              CPOL,
  input  logic              CPHA,
  input  logic              CONT,
  input  logic [CS_W-1:0]   CS_SEL,
  input  logic [DIV_W-1:0]  DIV,
  input  logic              WRITE,
  input  logic [DATA_W-1:0] INCOMING_DATA,
  input  logic              READ,
  output logic [DATA_W-1:0] OUTCOMING_DATA,
  input  logic              OVF_CLR,
  output logic              TX_FULL,
  output logic              TX_EMPTY,
  output logic              RX_FULL,
  output logic              RX_EMPTY,
  output logic              BUSY,
  output logic              RX_OVF,
  output logic              S_CLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic [NUM_CS-1:0] CS_N
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = $clog2(2 * DATA_W + 1);
  localparam logic [EW-1:0] FIRST_EDGE = EW'(1);
  localparam logic [EW-1:0] LAST_EDGE  = EW'(2 * DATA_W);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t            state_reg;
  logic [DIV_W-1:0]  div_reg, div_cnt_reg;
  logic [EW-1:0]     edge_cnt_reg, edge_idx;
  logic              cpha_reg, hold_phase_reg, sclk_reg, mosi_reg, ovf_reg;
  logic [NUM_CS-1:0] cs_n_reg, cs_dec;
  logic [DATA_W-1:0] tx_shift_reg, rx_shift_reg, rx_dout_reg;

  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]       tx_wr_reg, tx_rd_reg, rx_wr_reg, rx_rd_reg, rx_wr_next, rx_rd_next;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              tx_push, tx_pop, rx_push, rx_accept, rx_pop;
  logic [DATA_W-1:0] tx_head, rx_word, rx_head_next;
  logic              half_done, edge_now, sample_now, shift_now, last_edge, can_start, cont_go;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
      assign cs_dec[gi] = (CS_SEL != CS_W'(gi));
    end
  endgenerate

  assign tx_empty = (tx_wr_reg == tx_rd_reg);
  assign tx_full  = (tx_wr_reg == {~tx_rd_reg[AW], tx_rd_reg[AW-1:0]});
  assign rx_empty = (rx_wr_reg == rx_rd_reg);
  assign rx_full  = (rx_wr_reg == {~rx_rd_reg[AW], rx_rd_reg[AW-1:0]});
  assign tx_head  = tx_mem[tx_rd_reg[AW-1:0]];

  // Even/odd edge roles swap with CPHA; edge 1 and the final edge never move MOSI.
  assign half_done  = (div_cnt_reg == div_reg);
  assign edge_idx   = edge_cnt_reg + FIRST_EDGE;
  assign edge_now   = (state_reg == SHIFT) && half_done;
  assign sample_now = edge_now && (edge_idx[0] ^ cpha_reg);
  assign shift_now  = edge_now && !(edge_idx[0] ^ cpha_reg) &&
                      (edge_idx != FIRST_EDGE) && (edge_idx != LAST_EDGE);
  assign last_edge  = edge_now && (edge_idx == LAST_EDGE);
  assign can_start  = ENABLE && !tx_empty;
  assign cont_go    = last_edge && CONT && can_start;
  assign tx_pop     = ((state_reg == IDLE) && can_start) || cont_go;
  assign tx_push    = WRITE && (!tx_full || tx_pop);

  // Frame-end bookkeeping happens on the last edge itself, so a frame is exactly 2*DATA_W+3 half-periods.
  assign rx_push      = last_edge;
  assign rx_word      = sample_now ? {rx_shift_reg[DATA_W-2:0], MISO} : rx_shift_reg;
  assign rx_pop       = READ && !rx_empty;
  assign rx_accept    = rx_push && (!rx_full || rx_pop);
  assign rx_wr_next   = rx_wr_reg + {{AW{1'b0}}, rx_accept};
  assign rx_rd_next   = rx_rd_reg + {{AW{1'b0}}, rx_pop};
  assign rx_head_next = (rx_accept && (rx_rd_next == rx_wr_reg)) ? rx_word
                                                                 : rx_mem[rx_rd_next[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (tx_push)   tx_mem[tx_wr_reg[AW-1:0]] <= INCOMING_DATA;
    if (rx_accept) rx_mem[rx_wr_reg[AW-1:0]] <= rx_word;
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      tx_wr_reg   <= '0;
      tx_rd_reg   <= '0;
      rx_wr_reg   <= '0;
      rx_rd_reg   <= '0;
      rx_dout_reg <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      tx_wr_reg <= tx_wr_reg + {{AW{1'b0}}, tx_push};
      tx_rd_reg <= tx_rd_reg + {{AW{1'b0}}, tx_pop};
      rx_wr_reg <= rx_wr_next;
      rx_rd_reg <= rx_rd_next;
      // Head register refreshes on a pop or on the first word into an empty FIFO; holds when drained.
      if ((rx_pop || (rx_empty && rx_accept)) && (rx_wr_next != rx_rd_next))
        rx_dout_reg <= rx_head_next;
      if (rx_push && !rx_accept) ovf_reg <= 1'b1;
      else if (OVF_CLR)          ovf_reg <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_reg      <= IDLE;
      div_reg        <= '0;
      div_cnt_reg    <= '0;
      edge_cnt_reg   <= '0;
      cpha_reg       <= 1'b0;
      hold_phase_reg <= 1'b0;
      sclk_reg       <= 1'b0;
      mosi_reg       <= 1'b0;
      cs_n_reg       <= '1;
      tx_shift_reg   <= '0;
      rx_shift_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          sclk_reg <= CPOL;
          if (can_start) begin
            state_reg    <= SETUP;
            div_reg      <= DIV;
            cpha_reg     <= CPHA;
            cs_n_reg     <= cs_dec;
            div_cnt_reg  <= '0;
            edge_cnt_reg <= '0;
            tx_shift_reg <= tx_head;
            mosi_reg     <= tx_head[DATA_W-1];
          end
        end
        SETUP: begin
          if (half_done) begin
            state_reg   <= SHIFT;
            div_cnt_reg <= '0;
          end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
          end
        end
        SHIFT: begin
          if (half_done) begin
            div_cnt_reg  <= '0;
            sclk_reg     <= ~sclk_reg;
            edge_cnt_reg <= edge_idx;
            if (sample_now) rx_shift_reg <= {rx_shift_reg[DATA_W-2:0], MISO};
            if (shift_now) begin
              tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
              mosi_reg     <= tx_shift_reg[DATA_W-2];
            end
            if (last_edge) begin
              if (cont_go) begin
                state_reg    <= SETUP;
                edge_cnt_reg <= '0;
                tx_shift_reg <= tx_head;
                mosi_reg     <= tx_head[DATA_W-1];
              end else begin
                state_reg      <= HOLD;
                hold_phase_reg <= 1'b0;
              end
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
          end
        end
        HOLD: begin
          if (half_done) begin
            div_cnt_reg <= '0;
            if (!hold_phase_reg) begin
              hold_phase_reg <= 1'b1;
              cs_n_reg       <= '1;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign OUTCOMING_DATA = rx_dout_reg;
  assign TX_FULL        = tx_full;
  assign TX_EMPTY       = tx_empty;
  assign RX_FULL        = rx_full;
  assign RX_EMPTY       = rx_empty;
  assign BUSY           = (state_reg != IDLE);
  assign RX_OVF         = ovf_reg;
  assign S_CLK          = sclk_reg;
  assign MOSI           = mosi_reg;
  assign CS_N           = cs_n_reg;
endmodule
